// File: rtl/aes_pkg.sv
// aes_pkg: byte width and arbiter FSM states shared by the S-box arbiter and the round controller
package aes_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {ARB = 1'b0, LOCK_B = 1'b1} arb_state_t;
endpackage

// File: rtl/sbox.sv
// sbox: combinational AES forward S-box lookup
module sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] dout
);
  localparam logic [BYTE_W-1:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign dout = SBOX[data];
endmodule

// File: rtl/sbox_arbiter.sv
// sbox_arbiter: shares one AES S-box between the SubBytes stream (A) and key expansion (B),
// with registered per-port result slots under valid/ack and a B burst lock for SubWord.
module sbox_arbiter
  import aes_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_in,
  input  logic [BYTE_W-1:0] a_data_in,
  output logic              a_ready_out,
  output logic              a_valid_out,
  output logic [BYTE_W-1:0] a_data_out,
  input  logic              a_ack_in,
  input  logic              b_valid_in,
  input  logic [BYTE_W-1:0] b_data_in,
  input  logic              b_last_in,
  output logic              b_ready_out,
  output logic              b_valid_out,
  output logic [BYTE_W-1:0] b_data_out,
  input  logic              b_ack_in,
  output logic [CNT_W-1:0]  a_grant_cnt,
  output logic [CNT_W-1:0]  b_grant_cnt,
  output logic              locked_out
);
  arb_state_t r_state, w_next;
  logic r_last_b, r_a_vld, r_b_vld;
  logic [BYTE_W-1:0] r_a_dat, r_b_dat, w_sin, w_sout;
  logic [CNT_W-1:0] r_a_cnt, r_b_cnt;
  logic w_a_elig, w_b_elig, w_gnt_a, w_gnt_b;
  // a slot being acked this cycle can take a new result (ack bypass)
  assign w_a_elig = a_valid_in && (!r_a_vld || a_ack_in);
  assign w_b_elig = b_valid_in && (!r_b_vld || b_ack_in);
  always_comb begin
    w_gnt_b = !rst && w_b_elig &&
              (r_state == LOCK_B || !w_a_elig || FIXED_PRIO != 0 || !r_last_b);
    w_gnt_a = !rst && w_a_elig && r_state == ARB && !w_gnt_b;
    w_next  = w_gnt_b ? (b_last_in ? ARB : LOCK_B) : r_state;
  end
  assign w_sin = w_gnt_b ? b_data_in : a_data_in;
  sbox u_sbox (.data(w_sin), .dout(w_sout));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB;
      r_last_b <= 1'b1;
      r_a_vld  <= 1'b0;
      r_b_vld  <= 1'b0;
      r_a_dat  <= '0;
      r_b_dat  <= '0;
      r_a_cnt  <= '0;
      r_b_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_a || w_gnt_b) r_last_b <= w_gnt_b;
      if (w_gnt_a) begin
        r_a_vld <= 1'b1;
        r_a_dat <= w_sout;
        r_a_cnt <= r_a_cnt + 1'b1;
      end else if (a_ack_in) r_a_vld <= 1'b0;
      if (w_gnt_b) begin
        r_b_vld <= 1'b1;
        r_b_dat <= w_sout;
        r_b_cnt <= r_b_cnt + 1'b1;
      end else if (b_ack_in) r_b_vld <= 1'b0;
    end
  end
  assign a_ready_out = w_gnt_a;
  assign b_ready_out = w_gnt_b;
  assign a_valid_out = r_a_vld;
  assign b_valid_out = r_b_vld;
  assign a_data_out  = r_a_dat;
  assign b_data_out  = r_b_dat;
  assign a_grant_cnt = r_a_cnt;
  assign b_grant_cnt = r_b_cnt;
  assign locked_out  = r_state == LOCK_B;
endmodule

// File: tb/tb_sbox_arbiter.sv
// tb_sbox_arbiter: directed bench; expected results go into per-port queues, a monitor pops them on consume
module tb_sbox_arbiter;
  logic clk = 0, rst = 1;
  logic av = 0, aa = 0, bv = 0, ba = 0, bl = 0;
  logic [7:0] ad = 0, bd = 0;
  logic ar, avo, br, bvo, lk;
  logic [7:0] ado, bdo;
  logic [15:0] acnt, bcnt;
  logic fav = 0, fbv = 0;
  logic [7:0] fad = 0, fbd = 0;
  logic far, favo, fbr, fbvo, flk;
  logic [7:0] fado, fbdo;
  logic [3:0] facnt, fbcnt;
  int total = 0, passed = 0;
  logic [7:0] qa[$], qb[$];
  logic [7:0] e;
  logic [7:0] burst_in [4], burst_out [4];

  always #5 clk = ~clk;

  sbox_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid_in(av), .a_data_in(ad), .a_ready_out(ar), .a_valid_out(avo), .a_data_out(ado), .a_ack_in(aa),
    .b_valid_in(bv), .b_data_in(bd), .b_last_in(bl), .b_ready_out(br), .b_valid_out(bvo), .b_data_out(bdo),
    .b_ack_in(ba), .a_grant_cnt(acnt), .b_grant_cnt(bcnt), .locked_out(lk));

  sbox_arbiter #(.FIXED_PRIO(1), .CNT_W(4)) dut_fp (
    .clk(clk), .rst(rst),
    .a_valid_in(fav), .a_data_in(fad), .a_ready_out(far), .a_valid_out(favo), .a_data_out(fado), .a_ack_in(1'b1),
    .b_valid_in(fbv), .b_data_in(fbd), .b_last_in(1'b1), .b_ready_out(fbr), .b_valid_out(fbvo), .b_data_out(fbdo),
    .b_ack_in(1'b1), .a_grant_cnt(facnt), .b_grant_cnt(fbcnt), .locked_out(flk));

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
  endtask

  task automatic cyc(input logic er, input logic eb, input logic el);
    @(negedge clk);
    chk("a_ready", int'(ar), int'(er));
    chk("b_ready", int'(br), int'(eb));
    chk("locked", int'(lk), int'(el));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && avo && aa) begin
      if (qa.size() == 0) chk("a_unexpected_result", int'(ado), -1);
      else begin e = qa.pop_front(); chk("a_data", int'(ado), int'(e)); end
    end
    if (!rst && bvo && ba) begin
      if (qb.size() == 0) chk("b_unexpected_result", int'(bdo), -1);
      else begin e = qb.pop_front(); chk("b_data", int'(bdo), int'(e)); end
    end
  end

  initial begin
    burst_in  = '{8'h09, 8'hcf, 8'h4f, 8'h3c};
    burst_out = '{8'h01, 8'h8a, 8'h84, 8'heb};
    av = 1; bv = 1; fav = 1; fbv = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", int'(ar), 0);
    chk("rst_b_ready", int'(br), 0);
    chk("rst_fa_ready", int'(far), 0);
    chk("rst_a_valid", int'(avo), 0);
    chk("rst_b_valid", int'(bvo), 0);
    chk("rst_a_data", int'(ado), 0);
    chk("rst_b_data", int'(bdo), 0);
    chk("rst_a_cnt", int'(acnt), 0);
    chk("rst_b_cnt", int'(bcnt), 0);
    chk("rst_locked", int'(lk), 0);
    @(posedge clk); #1;
    rst = 0; av = 0; bv = 0; fav = 0; fbv = 0; aa = 1; ba = 1;
    // single A lookup
    av = 1; ad = 8'h00; qa.push_back(8'h63);
    cyc(1, 0, 0);
    av = 0;
    chk("a_valid_1cyc", int'(avo), 1);
    cyc(0, 0, 0);
    chk("a_cnt_single", int'(acnt), 1);
    // round-robin contention; last grant was A so B goes first
    av = 1; bv = 1; ad = 8'h53; bd = 8'h01; bl = 1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin qb.push_back(8'h7c); cyc(0, 1, 0); end
      else begin qa.push_back(8'hed); cyc(1, 0, 0); end
    end
    av = 0; bv = 0;
    chk("a_cnt_rr", int'(acnt), 3);
    chk("b_cnt_rr", int'(bcnt), 2);
    // B SubWord burst with A pending throughout
    av = 1; ad = 8'h53; bv = 1;
    for (int i = 0; i < 4; i++) begin
      bd = burst_in[i]; bl = (i == 3); qb.push_back(burst_out[i]);
      cyc(0, 1, i != 0);
    end
    bv = 0; bl = 0; qa.push_back(8'hed);
    cyc(1, 0, 0);
    av = 0;
    chk("b_cnt_burst", int'(bcnt), 6);
    chk("a_cnt_burst", int'(acnt), 4);
    // hold A result without ack, then ack + new request in the same cycle
    av = 1; ad = 8'h10; qa.push_back(8'hca);
    cyc(1, 0, 0);
    aa = 0; ad = 8'h20;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk("a_hold_valid", int'(avo), 1);
      chk("a_hold_data", int'(ado), 8'hca);
    end
    aa = 1; qa.push_back(8'hb7);
    cyc(1, 0, 0);
    av = 0;
    cyc(0, 0, 0);
    chk("a_cnt_hold", int'(acnt), 6);
    // fill both slots, lock on B, then reset asynchronously mid-cycle
    aa = 0; ba = 0;
    av = 1; ad = 8'h00;
    cyc(1, 0, 0);
    av = 0; bv = 1; bd = 8'h01; bl = 0;
    cyc(0, 1, 0);
    av = 1;
    cyc(0, 0, 1);
    chk("full_a_valid", int'(avo), 1);
    chk("full_b_valid", int'(bvo), 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_a_valid", int'(avo), 0);
    chk("mid_rst_b_valid", int'(bvo), 0);
    chk("mid_rst_locked", int'(lk), 0);
    chk("mid_rst_a_cnt", int'(acnt), 0);
    chk("mid_rst_b_cnt", int'(bcnt), 0);
    chk("mid_rst_a_ready", int'(ar), 0);
    chk("mid_rst_b_ready", int'(br), 0);
    @(posedge clk); #1;
    rst = 0; aa = 1; ba = 1; ad = 8'h53; bd = 8'h01; bl = 1;
    qa.push_back(8'hed);
    cyc(1, 0, 0);
    qb.push_back(8'h7c);
    cyc(0, 1, 0);
    av = 0; bv = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    // fixed priority and 4-bit counter wrap on the second instance
    fav = 1; fbv = 1; fad = 8'h00; fbd = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fp_a_ready", int'(far), 0);
      chk("fp_b_ready", int'(fbr), 1);
      @(posedge clk); #1;
    end
    fbv = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk("fp_a_ready_alone", int'(far), 1);
      @(posedge clk); #1;
    end
    fav = 0;
    @(negedge clk);
    chk("fp_a_data", int'(fado), 8'h63);
    chk("fp_b_data", int'(fbdo), 8'h7c);
    chk("fp_a_cnt_wrap", int'(facnt), 3);
    chk("fp_b_cnt", int'(fbcnt), 3);
    chk("fp_locked", int'(flk), 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sbox_arbiter.md
# sbox_arbiter

Shares one combinational AES S-box between two byte-serial requesters: port A (the SubBytes pixel stream) and port B (the key-expansion SubWord engine). One lookup is accepted per cycle; each result is registered into a per-port output slot and held under a valid/ack handshake. Port B may lock the arbiter for a multi-byte SubWord burst so that the four bytes of a key word are looked up back-to-back. The block sits between the pixel front end and key schedule on one side and the downstream round logic on the other.

## Interface
- FIXED_PRIO, default 0: 0 = round-robin between A and B; 1 = B always wins a conflict.
- CNT_W, default 16: width of the per-port grant counters.

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid_in  in  1  A request valid
- a_data_in  in  8  A byte to substitute
- a_ready_out  out  1  A request accepted this cycle
- a_valid_out  out  1  A result valid
- a_data_out  out  8  A substituted byte
- a_ack_in  in  1  A consumer accepted result
- b_valid_in, b_data_in[7:0], b_ready_out, b_valid_out, b_data_out[7:0], b_ack_in: as A, for port B
- b_last_in  in  1  B beat is last of burst (1 for single lookups)
- a_grant_cnt  out  CNT_W  A lookups accepted since reset, wraps
- b_grant_cnt  out  CNT_W  B lookups accepted since reset, wraps
- locked_out  out  1  arbiter is in LOCK_B

## Operation
- Slot X is free when x_valid_out=0, or x_valid_out=1 and x_ack_in=1 in the same cycle (ack bypass).
- X is eligible when x_valid_in=1 and slot X is free.
- Grant at most one port per cycle; x_ready_out=1 exactly in the granted cycle (combinational from valid, slot state, FSM). An accept is x_valid_in && x_ready_out.
- On accept: S-box output for x_data_in is captured into x_data_out; x_valid_out set. On ack with no same-cycle accept: x_valid_out cleared; x_data_out holds its last value.
- x_data_out is stable while x_valid_out=1 and x_ack_in=0.
- FSM states:
  - ARB: both eligible -> FIXED_PRIO=1 grants B; FIXED_PRIO=0 grants the port not granted last (last_grant register, reset value B, so A wins the first conflict). One eligible -> grant it. B accept with b_last_in=0 -> LOCK_B.
  - LOCK_B: A is never granted. B is granted whenever eligible. B accept with b_last_in=1 -> ARB. B ineligible -> stall in LOCK_B (no timeout).
- last_grant updates on every accept, including in LOCK_B.
- Grant counters increment by 1 per accept and wrap modulo 2^CNT_W.
- locked_out = 1 iff state is LOCK_B.

## Timing
- Reset (async assert, sync release): state ARB, last_grant B, all valid_out 0, data_out 0x00, counters 0, locked_out 0. ready_out outputs are 0 while reset is asserted.
- Latency: accept at edge k -> x_valid_out=1 with result after edge k (1 cycle).
- Throughput: one lookup per cycle total. A single port with ack held high sustains one result per cycle.
- Under round-robin contention each port gets every other cycle.
- Reset mid-burst or mid-handshake: held results are discarded, FSM returns to ARB, no output valid after reset.
- x_ack_in while x_valid_out=0 is ignored.

## Structure
- aes_pkg holds BYTE_W=8 and the FSM state enum (ARB, LOCK_B). Both are shared with the round controller.
- Instantiates the existing sbox module (data -> dout) as its only sub-module: one instance, input muxed by grant.
- Grant logic, FSM and slot registers stay in this module.

## Test plan
- Single A request 0x00, ack held 1 -> a_valid_out after 1 cycle, a_data_out=0x63; a_grant_cnt=1.
- A and B both valid every cycle (A=0x53, B=0x01), acks 1, FIXED_PRIO=0 -> grants alternate A,B,A,...; results 0xED and 0x7C. FIXED_PRIO=1 -> only B granted while B valid.
- B burst 0x09,0xCF,0x4F,0x3C (last on 4th) with A valid throughout -> 4 consecutive B grants, results 0x01,0x8A,0x84,0xEB; locked_out high after first beat until the last beat is accepted; A granted next cycle.
- A result held with a_ack_in=0 for 5 cycles -> a_ready_out=0, a_data_out stable; ack and new request in same cycle -> accepted with no bubble.
- rst asserted during LOCK_B with both slots full -> all valid_out 0, locked_out 0, counters 0 immediately; first conflict after release grants A.
- 2^CNT_W+3 A accepts with CNT_W=4 -> a_grant_cnt reads 3.
